multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Parametrised multi-cycle MIPS main controller. It replaces the single-cycle opcode decoder with a Moore/Mealy FSM that sequences fetch, decode, execute, memory and writeback over several cycles.
- It drives the shared-datapath control signals: PC, IR, ALU muxes, memory and register file.
- It adds a memory ready handshake, ADDI and J support, and an illegal-opcode flag.

Parameters:
- MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = mem_ready is ignored and treated as 1.
- ENABLE_ADDI, 1, 1 = opcode 8 (ADDI) is executed; 0 = opcode 8 is illegal.
- ENABLE_JUMP, 1, 1 = opcode 2 (J) is executed; 0 = opcode 2 is illegal.
- ALU_OP_W, 2, width of alu_op. Must be ≥2; upper bits are driven 0.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26]; sampled in DECODE only.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (ANDed in datapath).
- i_or_d  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  writeback source: 0 = ALUOut, 1 = MDR.
- reg_dst  out  1  destination: 0 = rt, 1 = rd.
- reg_write  out  1  register file write.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  2  0 = B, 1 = constant 4, 2 = sign-extended imm, 3 = sign-extended imm<<2.
- alu_op  out  ALU_OP_W  0 = add, 1 = sub, 2 = use funct.
- pc_source  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- state_o  out  4  current state encoding (debug).

Behaviour:
- States and encodings:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5
  - EXEC=6, ALU_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11
  - Encodings 12-15 are unreachable; decode them as FETCH.
- Reset:
  - While rst=1, every output is 0, including state_o and illegal_op.
  - The next state is FETCH.
  - Reset mid-instruction aborts the instruction with no further writes.
- Outputs are decoded combinationally from the state. mem_ready gates only pc_write and ir_write in FETCH, and the state advance out of FETCH, MEM_RD and MEM_WR.
- FETCH:
  - Always drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0.
  - ir_write and pc_write assert only when mem_ready=1; the FSM then goes to DECODE.
  - Otherwise it holds in FETCH with mem_read still high.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=3, alu_op=0 (branch target precompute).
  - Next state by opcode:
    - 0 → EXEC
    - 35 or 43 → MEM_ADDR
    - 4 → BRANCH
    - 2 → JUMP (if ENABLE_JUMP)
    - 8 → ADDI_EX (if ENABLE_ADDI)
  - Any other opcode, or a disabled one, pulses illegal_op for this cycle and goes to FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=0. Goes to MEM_RD if opcode was 35, else MEM_WR. Use a registered copy of the opcode class latched in DECODE.
- MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Then FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Holds until mem_ready, then FETCH.
- EXEC → ALU_WB: EXEC drives alu_src_a=1, alu_src_b=0, alu_op=2. ALU_WB drives reg_write=1, reg_dst=1, mem_to_reg=0.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1. Then FETCH.
- JUMP: pc_write=1, pc_source=2. Then FETCH.
- ADDI_EX → ADDI_WB: ADDI_EX drives alu_src_a=1, alu_src_b=2, alu_op=0. ADDI_WB drives reg_write=1, reg_dst=0, mem_to_reg=0.
- Signals not listed for a state are 0.
- Latency, zero-wait memory: R 4 cycles, LW 5, SW 4, BEQ 3, J 3, ADDI 4. Each waiting memory cycle adds 1.
- mem_read and mem_write are never asserted together.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants (R=0, J=2, BEQ=4, ADDI=8, LW=35, SW=43)
  - state encodings
  - alu_src_b, alu_op and pc_source encodings
  - instruction-class enum
- One sub-module, mc_opcode_class: combinational opcode + enable parameters → class and illegal.

Test Plan:
- Reset held 3 cycles with mem_ready=1: all outputs 0. After release, state_o=0, mem_read=1, ir_write=1, pc_write=1.
- R-type (opcode 0), mem_ready=1: state_o sequence 0,1,6,7,0. reg_write=1 only in state 7, with reg_dst=1.
- LW (35) with mem_ready low for 2 cycles in MEM_RD: sequence 0,1,2,3,3,3,4,0. i_or_d=1 in state 3. reg_write with mem_to_reg=1 in state 4.
- SW (43) then BEQ (4): SW gives 0,1,2,5,0 with mem_write=1 only in state 5. BEQ gives 0,1,8,0 with pc_write_cond=1, alu_op=1.
- ENABLE_JUMP=0, opcode 2: illegal_op=1 in DECODE for one cycle, then FETCH with no reg or memory write. With ENABLE_JUMP=1: JUMP state, pc_write=1, pc_source=2.
- rst asserted in MEM_WR while mem_ready=0: mem_write drops to 0 in the same cycle. The FSM restarts at FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared opcodes, state encodings and control field encodings
package mips_ctrl_pkg;

    // Opcode field values (IR[31:26]) understood by the controller
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    // FSM state encodings; these values are visible on state_o
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_ALU_WB   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11
    } state_t;

    // ALU operand B select
    localparam logic [1:0] SRCB_B       = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    // ALU operation request (low two bits of alu_op)
    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // Instruction class resolved in DECODE
    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_JUMP    = 3'd4,
        CLS_ADDI    = 3'd5,
        CLS_ILLEGAL = 3'd6
    } op_class_t;

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - controller <-> datapath/memory signal bundle
interface multicycle_control_if #(
    parameter int ALU_OP_W = 2
);
    logic [5:0]          opcode;
    logic                mem_ready;
    logic                pc_write;
    logic                pc_write_cond;
    logic                i_or_d;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                mem_to_reg;
    logic                reg_dst;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic [1:0]          pc_source;
    logic                illegal_op;
    logic [3:0]          state_o;

    // Controller side
    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, state_o
    );

    // Datapath / memory side
    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, state_o
    );
endinterface

// File: rtl/mc_opcode_class.sv
// rtl/mc_opcode_class.sv - opcode to instruction class decoder
module mc_opcode_class
    import mips_ctrl_pkg::*;
#(
    parameter bit ENABLE_ADDI = 1'b1,
    parameter bit ENABLE_JUMP = 1'b1
) (
    input  logic [5:0] opcode,
    output op_class_t  op_class,
    output logic       illegal
);

    // Map opcode to class; disabled optional opcodes fall into the illegal class
    always_comb begin
        op_class = CLS_ILLEGAL;
        case (opcode)
            OP_RTYPE: op_class = CLS_RTYPE;
            OP_LW:    op_class = CLS_LOAD;
            OP_SW:    op_class = CLS_STORE;
            OP_BEQ:   op_class = CLS_BRANCH;
            OP_J:     op_class = ENABLE_JUMP ? CLS_JUMP : CLS_ILLEGAL;
            OP_ADDI:  op_class = ENABLE_ADDI ? CLS_ADDI : CLS_ILLEGAL;
            default:  op_class = CLS_ILLEGAL;
        endcase
        illegal = (op_class == CLS_ILLEGAL);
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS main control FSM
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit ENABLE_ADDI   = 1'b1,
    parameter bit ENABLE_JUMP   = 1'b1,
    parameter int ALU_OP_W      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);

    state_t    state;
    state_t    state_next;
    op_class_t cls_dec;
    op_class_t cls_q;
    logic      illegal_dec;
    logic      ready;

    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;

    // Without the handshake every memory access completes in one cycle
    assign ready = (MEM_HANDSHAKE == 1'b0) || bus.mem_ready;

    mc_opcode_class #(
        .ENABLE_ADDI (ENABLE_ADDI),
        .ENABLE_JUMP (ENABLE_JUMP)
    ) u_class (
        .opcode   (bus.opcode),
        .op_class (cls_dec),
        .illegal  (illegal_dec)
    );

    // State register; the class is latched in DECODE because IR may change later
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            cls_q <= CLS_ILLEGAL;
        end else begin
            state <= state_next;
            if (state == S_DECODE) begin
                cls_q <= cls_dec;
            end
        end
    end

    // Next-state sequencing; unknown encodings return to FETCH
    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:    state_next = ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (cls_dec)
                    CLS_RTYPE:  state_next = S_EXEC;
                    CLS_LOAD:   state_next = S_MEM_ADDR;
                    CLS_STORE:  state_next = S_MEM_ADDR;
                    CLS_BRANCH: state_next = S_BRANCH;
                    CLS_JUMP:   state_next = S_JUMP;
                    CLS_ADDI:   state_next = S_ADDI_EX;
                    default:    state_next = S_FETCH;
                endcase
            end
            S_MEM_ADDR: state_next = (cls_q == CLS_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_next = ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:   state_next = S_FETCH;
            S_MEM_WR:   state_next = ready ? S_FETCH : S_MEM_WR;
            S_EXEC:     state_next = S_ALU_WB;
            S_ALU_WB:   state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_JUMP:     state_next = S_FETCH;
            S_ADDI_EX:  state_next = S_ADDI_WB;
            S_ADDI_WB:  state_next = S_FETCH;
            default:    state_next = S_FETCH;
        endcase
    end

    // Control decode from state; reset forces every output low immediately
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_ADD;
        pc_source     = PCSRC_ALU;
        illegal_op    = 1'b0;
        if (!rst) begin
            case (state)
                S_DECODE: begin
                    alu_src_b  = SRCB_IMM_SH2;
                    illegal_op = illegal_dec;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FUNCT;
                end
                S_ALU_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALU_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = PCSRC_JUMP;
                end
                S_ADDI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                S_ADDI_WB: begin
                    reg_write = 1'b1;
                end
                // FETCH and the unreachable encodings: PC+4 and instruction read
                default: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    pc_write  = ready;
                    ir_write  = ready;
                end
            endcase
        end
    end

    assign bus.pc_write      = pc_write;
    assign bus.pc_write_cond = pc_write_cond;
    assign bus.i_or_d        = i_or_d;
    assign bus.mem_read      = mem_read;
    assign bus.mem_write     = mem_write;
    assign bus.ir_write      = ir_write;
    assign bus.mem_to_reg    = mem_to_reg;
    assign bus.reg_dst       = reg_dst;
    assign bus.reg_write     = reg_write;
    assign bus.alu_src_a     = alu_src_a;
    assign bus.alu_src_b     = alu_src_b;
    assign bus.alu_op        = ALU_OP_W'(alu_op);
    assign bus.pc_source     = pc_source;
    assign bus.illegal_op    = illegal_op;
    assign bus.state_o       = rst ? 4'd0 : state;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control
module tb_multicycle_control;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    multicycle_control_if #(.ALU_OP_W(2)) bus_a ();
    multicycle_control_if #(.ALU_OP_W(3)) bus_b ();

    // Full-featured instance with memory handshake
    multicycle_control #(
        .MEM_HANDSHAKE (1'b1),
        .ENABLE_ADDI   (1'b1),
        .ENABLE_JUMP   (1'b1),
        .ALU_OP_W      (2)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.master)
    );

    // Reduced instance: no handshake, no ADDI, no J, wider alu_op
    multicycle_control #(
        .MEM_HANDSHAKE (1'b0),
        .ENABLE_ADDI   (1'b0),
        .ENABLE_JUMP   (1'b0),
        .ALU_OP_W      (3)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.master)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic ctrl_t observe(input bit sel);
        ctrl_t c;
        if (sel) begin
            c = '{bus_b.pc_write, bus_b.pc_write_cond, bus_b.i_or_d, bus_b.mem_read,
                  bus_b.mem_write, bus_b.ir_write, bus_b.mem_to_reg, bus_b.reg_dst,
                  bus_b.reg_write, bus_b.alu_src_a, bus_b.alu_src_b, bus_b.alu_op,
                  bus_b.pc_source, bus_b.illegal_op};
        end else begin
            c = '{bus_a.pc_write, bus_a.pc_write_cond, bus_a.i_or_d, bus_a.mem_read,
                  bus_a.mem_write, bus_a.ir_write, bus_a.mem_to_reg, bus_a.reg_dst,
                  bus_a.reg_write, bus_a.alu_src_a, bus_a.alu_src_b, {1'b0, bus_a.alu_op},
                  bus_a.pc_source, bus_a.illegal_op};
        end
        return c;
    endfunction

    function automatic logic [3:0] observe_state(input bit sel);
        return sel ? bus_b.state_o : bus_a.state_o;
    endfunction

    // Control-signal table of each step of the instruction cycle
    function automatic ctrl_t exp_ctrl(input int st, input bit rdy, input bit ill);
        ctrl_t c;
        c = '0;
        case (st)
            0:  begin c.mem_read = 1; c.alu_src_b = 2'd1; c.pc_write = rdy; c.ir_write = rdy; end
            1:  begin c.alu_src_b = 2'd3; c.illegal_op = ill; end
            2:  begin c.alu_src_a = 1; c.alu_src_b = 2'd2; end
            3:  begin c.mem_read = 1; c.i_or_d = 1; end
            4:  begin c.reg_write = 1; c.mem_to_reg = 1; end
            5:  begin c.mem_write = 1; c.i_or_d = 1; end
            6:  begin c.alu_src_a = 1; c.alu_op = 3'd2; end
            7:  begin c.reg_write = 1; c.reg_dst = 1; end
            8:  begin c.alu_src_a = 1; c.alu_op = 3'd1; c.pc_write_cond = 1; c.pc_source = 2'd1; end
            9:  begin c.pc_write = 1; c.pc_source = 2'd2; end
            10: begin c.alu_src_a = 1; c.alu_src_b = 2'd2; end
            11: begin c.reg_write = 1; end
            default: ;
        endcase
        return c;
    endfunction

    task automatic drive(input bit sel, input logic [5:0] op, input bit rdy);
        if (sel) begin
            bus_b.opcode    = op;
            bus_b.mem_ready = rdy;
        end else begin
            bus_a.opcode    = op;
            bus_a.mem_ready = rdy;
        end
    endtask

    // Hold reset three cycles with mem_ready high; everything must read zero
    task automatic reset_phase();
        @(negedge clk);
        rst = 1'b1;
        drive(0, 6'd0, 1'b1);
        drive(1, 6'd0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("rst_ctrl_a%0d", k), 32'(observe(0)), 32'd0);
            check($sformatf("rst_state_a%0d", k), 32'(observe_state(0)), 32'd0);
            check($sformatf("rst_ctrl_b%0d", k), 32'(observe(1)), 32'd0);
            check($sformatf("rst_state_b%0d", k), 32'(observe_state(1)), 32'd0);
            if (k < 2) @(negedge clk);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Expected per-cycle step list and mem_ready plan for one instruction.
    // sel=1 is the reduced instance: waits vanish and J/ADDI are illegal.
    task automatic run_instr(input bit sel, input logic [5:0] op, input int wf,
                             input int wm, input int ncyc);
        int  st_q[$];
        bit  rdy_q[$];
        bit  hs;
        bit  ill;
        int  n;
        hs  = !sel;
        ill = 1'b0;
        for (int k = 0; k < (hs ? wf : 0); k++) begin st_q.push_back(0); rdy_q.push_back(1'b0); end
        st_q.push_back(0); rdy_q.push_back(hs ? 1'b1 : 1'($urandom_range(0, 1)));
        st_q.push_back(1); rdy_q.push_back(1'($urandom_range(0, 1)));
        case (op)
            6'd0:  begin st_q.push_back(6); st_q.push_back(7); end
            6'd4:  begin st_q.push_back(8); end
            6'd35: begin
                st_q.push_back(2);
                for (int k = 0; k < (hs ? wm : 0); k++) st_q.push_back(-3);
                st_q.push_back(3);
                st_q.push_back(4);
            end
            6'd43: begin
                st_q.push_back(2);
                for (int k = 0; k < (hs ? wm : 0); k++) st_q.push_back(-5);
                st_q.push_back(5);
            end
            6'd2:  if (!sel) st_q.push_back(9); else ill = 1'b1;
            6'd8:  if (!sel) begin st_q.push_back(10); st_q.push_back(11); end else ill = 1'b1;
            default: ill = 1'b1;
        endcase
        // Waiting memory steps carry negative tags; resolve them into state + ready plan
        for (int i = rdy_q.size(); i < st_q.size(); i++) begin
            if (st_q[i] < 0) begin
                st_q[i] = -st_q[i];
                rdy_q.push_back(1'b0);
            end else if (hs && (st_q[i] == 3 || st_q[i] == 5)) begin
                rdy_q.push_back(1'b1);
            end else begin
                rdy_q.push_back(1'($urandom_range(0, 1)));
            end
        end
        n = (ncyc > 0 && ncyc < st_q.size()) ? ncyc : st_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(sel, (st_q[i] <= 1) ? op : 6'($urandom), rdy_q[i]);
            #1;
            check($sformatf("state s%0d op%0d c%0d", sel, op, i), 32'(observe_state(sel)), 32'(st_q[i]));
            check($sformatf("ctrl s%0d op%0d c%0d st%0d", sel, op, i, st_q[i]), 32'(observe(sel)),
                  32'(exp_ctrl(st_q[i], hs ? rdy_q[i] : 1'b1, ill && st_q[i] == 1)));
        end
    endtask

    logic [5:0] op_tab [6];
    logic [5:0] op_r;

    initial begin
        op_tab = '{6'd0, 6'd2, 6'd4, 6'd8, 6'd35, 6'd43};
        drive(0, 6'd0, 1'b1);
        drive(1, 6'd0, 1'b1);

        // Directed sequences on the full instance
        reset_phase();
        run_instr(0, 6'd0, 0, 0, 0);
        run_instr(0, 6'd35, 0, 2, 0);
        run_instr(0, 6'd43, 0, 0, 0);
        run_instr(0, 6'd4, 0, 0, 0);
        run_instr(0, 6'd2, 0, 0, 0);
        run_instr(0, 6'd8, 1, 0, 0);
        run_instr(0, 6'd63, 2, 0, 0);
        run_instr(0, 6'd0, 0, 0, 0);

        // Reset while stalled in MEM_WR must drop mem_write at once
        run_instr(0, 6'd43, 0, 5, 4);
        @(negedge clk);
        drive(0, 6'd0, 1'b0);
        #1;
        check("mwr_before_rst_state", 32'(observe_state(0)), 32'd5);
        check("mwr_before_rst_write", 32'(bus_a.mem_write), 32'd1);
        rst = 1'b1;
        #1;
        check("mwr_rst_write", 32'(bus_a.mem_write), 32'd0);
        check("mwr_rst_ctrl", 32'(observe(0)), 32'd0);
        check("mwr_rst_state", 32'(observe_state(0)), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        run_instr(0, 6'd0, 0, 0, 0);

        // Random instruction stream on the full instance
        for (int t = 0; t < 60; t++) begin
            op_r = ($urandom_range(0, 7) < 6) ? op_tab[$urandom_range(0, 5)] : 6'($urandom);
            run_instr(0, op_r, $urandom_range(0, 2), $urandom_range(0, 3), 0);
        end

        // Reduced instance: disabled J/ADDI are illegal, mem_ready ignored
        reset_phase();
        run_instr(1, 6'd2, 0, 0, 0);
        run_instr(1, 6'd8, 0, 0, 0);
        run_instr(1, 6'd35, 2, 2, 0);
        run_instr(1, 6'd43, 0, 3, 0);
        run_instr(1, 6'd0, 0, 0, 0);
        for (int t = 0; t < 60; t++) begin
            op_r = ($urandom_range(0, 7) < 6) ? op_tab[$urandom_range(0, 5)] : 6'($urandom);
            run_instr(1, op_r, $urandom_range(0, 2), $urandom_range(0, 3), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
